// File: rtl/ti_stop_pkg.sv
// ti_stop_pkg: shared definitions for the stop/decouple sequencer.
//   - state_e      : sequencer FSM states
//   - STOP_W, STOP_WR_BIT, STOP_RD_BIT : layout of one stop_req/stop_ack
//                    pair, identical to the AXI wrapper's stop interface
//   - MAX_PORTS    : widest port vector the helper function accepts
//   - all_acked()  : true when every masked port's ack pair equals val
package ti_stop_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_STOPPING   = 3'd1,
    ST_DECOUPLING = 3'd2,
    ST_HALTED     = 3'd3,
    ST_RELEASING  = 3'd4
  } state_e;

  localparam int STOP_W      = 2;
  localparam int STOP_WR_BIT = 0;
  localparam int STOP_RD_BIT = 1;
  localparam int MAX_PORTS   = 32;

  // Callers zero-extend their vectors to MAX_PORTS; zero mask bits make the
  // padding irrelevant.
  function automatic logic all_acked(
    input logic [STOP_W*MAX_PORTS-1:0] ack,
    input logic [MAX_PORTS-1:0]        mask,
    input logic [STOP_W-1:0]           val
  );
    logic ok;
    ok = 1'b1;
    for (int p = 0; p < MAX_PORTS; p++) begin
      if (mask[p] && (ack[STOP_W*p +: STOP_W] != val)) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/ti_stop_timeout_cnt.sv
// ti_stop_timeout_cnt: clear/enable up-counter with a terminal flag.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr_i     : synchronous clear (wins over en_i)
//   en_i      : count enable
//   term_o    : count has reached TIMEOUT_CYCLES-1
// The counter saturates at the terminal value so it can never wrap.
module ti_stop_timeout_cnt #(
  parameter int  TIMEOUT_CYCLES = 1024,
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next count: clear, increment below terminal, otherwise hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != TERM_VAL)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == TERM_VAL);

endmodule

// File: rtl/ti_stop_sequencer.sv
// ti_stop_sequencer: sequences stop/decouple handshakes of up to NUM_PORTS
// AXI wrappers so a state-capture host sees one halted/resumed interface.
// Ports:
//   clk, rst     : clock shared with the wrappers, async active-high reset
//   halt_req     : level, 1 = halt, 0 = run
//   port_mask    : participating ports, latched when a session starts
//   err_clr      : pulse, clears the sticky timeout_err
//   stop_req     : per-port {rd,wr} stop request pairs to the wrappers
//   stop_ack     : per-port {rd,wr} stop acknowledge pairs from the wrappers
//   decouple     : per-port decouple enable
//   halted       : all masked ports stopped and decoupled
//   busy         : sequence in progress (STOPPING/DECOUPLING/RELEASING)
//   timeout_err  : sticky, STOPPING gave up waiting for acks
//   pending      : masked ports not yet fully acked (STOPPING only)
// All outputs are registered and computed from the next state, so each one
// reflects the state the block is in during the same cycle.
module ti_stop_sequencer
  import ti_stop_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        halt_req,
  input  logic [NUM_PORTS-1:0]        port_mask,
  input  logic                        err_clr,
  output logic [STOP_W*NUM_PORTS-1:0] stop_req,
  input  logic [STOP_W*NUM_PORTS-1:0] stop_ack,
  output logic [NUM_PORTS-1:0]        decouple,
  output logic                        halted,
  output logic                        busy,
  output logic                        timeout_err,
  output logic [NUM_PORTS-1:0]        pending
);

  state_e                      state_q, state_d;
  logic [NUM_PORTS-1:0]        mask_q, mask_d;
  logic [STOP_W*NUM_PORTS-1:0] stop_req_q, stop_req_d;
  logic [NUM_PORTS-1:0]        decouple_q, decouple_d;
  logic                        halted_q, halted_d;
  logic                        busy_q, busy_d;
  logic                        timeout_err_q, timeout_err_d;
  logic [NUM_PORTS-1:0]        pending_q, pending_d;

  logic [STOP_W*MAX_PORTS-1:0] ack_ext_s;
  logic [MAX_PORTS-1:0]        mask_ext_s;
  logic [NUM_PORTS-1:0]        port_acked_s;
  logic [STOP_W*NUM_PORTS-1:0] req_pairs_s;
  logic                        all_set_s;
  logic                        all_clr_s;
  logic                        timeout_set_s;
  logic                        cnt_clr_s;
  logic                        cnt_en_s;
  logic                        cnt_term_s;

  // widen ack/mask to the helper's fixed width and flag fully acked ports
  always_comb begin
    ack_ext_s  = '0;
    mask_ext_s = '0;
    ack_ext_s[STOP_W*NUM_PORTS-1:0] = stop_ack;
    mask_ext_s[NUM_PORTS-1:0]       = mask_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_acked_s[p] = stop_ack[STOP_W*p + STOP_WR_BIT] &
                        stop_ack[STOP_W*p + STOP_RD_BIT];
    end
  end

  assign all_set_s = all_acked(ack_ext_s, mask_ext_s, 2'b11);
  assign all_clr_s = all_acked(ack_ext_s, mask_ext_s, 2'b00);

  // The counter is held clear in IDLE so it starts from 0 on STOPPING entry.
  assign cnt_clr_s = (state_q == ST_IDLE);
  assign cnt_en_s  = (state_q == ST_STOPPING);

  ti_stop_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr_s),
    .en_i   (cnt_en_s),
    .term_o (cnt_term_s)
  );

  // next state, mask latch and sticky error
  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    timeout_set_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (halt_req) begin
          state_d = ST_STOPPING;
          mask_d  = port_mask;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STOPPING: begin
        // ack-complete beats timeout, timeout beats abort
        if (all_set_s) begin
          state_d = ST_DECOUPLING;
        end else if (cnt_term_s) begin
          state_d       = ST_RELEASING;
          timeout_set_s = 1'b1;
        end else if (!halt_req) begin
          state_d = ST_RELEASING;
        end else begin
          state_d = ST_STOPPING;
        end
      end
      ST_DECOUPLING: begin
        state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (!halt_req) begin
          state_d = ST_RELEASING;
        end else begin
          state_d = ST_HALTED;
        end
      end
      ST_RELEASING: begin
        if (all_clr_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RELEASING;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // a timeout in the same cycle as err_clr keeps the error set
    if (timeout_set_s) begin
      timeout_err_d = 1'b1;
    end else if (err_clr) begin
      timeout_err_d = 1'b0;
    end else begin
      timeout_err_d = timeout_err_q;
    end
  end

  // output values for the state being entered
  always_comb begin
    stop_req_d = '0;
    decouple_d = '0;
    pending_d  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      req_pairs_s[STOP_W*p +: STOP_W] = {STOP_W{mask_d[p]}};
    end
    halted_d = (state_d == ST_HALTED);
    busy_d   = (state_d == ST_STOPPING) || (state_d == ST_DECOUPLING) ||
               (state_d == ST_RELEASING);
    case (state_d)
      ST_STOPPING: begin
        stop_req_d = req_pairs_s;
        pending_d  = mask_d & ~port_acked_s;
      end
      ST_DECOUPLING, ST_HALTED: begin
        stop_req_d = req_pairs_s;
        decouple_d = mask_d;
      end
      ST_RELEASING: begin
        // stop_req outlives decouple by exactly one cycle
        if (state_q != ST_RELEASING) begin
          stop_req_d = req_pairs_s;
        end else begin
          stop_req_d = '0;
        end
      end
      default: begin
        stop_req_d = '0;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mask_q        <= '0;
      stop_req_q    <= '0;
      decouple_q    <= '0;
      halted_q      <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      pending_q     <= '0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      stop_req_q    <= stop_req_d;
      decouple_q    <= decouple_d;
      halted_q      <= halted_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      pending_q     <= pending_d;
    end
  end

  assign stop_req    = stop_req_q;
  assign decouple    = decouple_q;
  assign halted      = halted_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_ti_stop_sequencer.sv
// tb_ti_stop_sequencer: directed bench for ti_stop_sequencer with
// NUM_PORTS=4, TIMEOUT_CYCLES=16. A wrapper model echoes stop_req back
// as stop_ack three cycles later, gated per bit by ack_en.
module tb_ti_stop_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       halt_req;
  logic [3:0] port_mask;
  logic       err_clr;
  logic [7:0] stop_req;
  logic [7:0] stop_ack;
  logic [3:0] decouple;
  logic       halted;
  logic       busy;
  logic       timeout_err;
  logic [3:0] pending;

  logic [7:0] h0, h1, h2;
  logic [7:0] ack_en;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] watch_mask;
  logic       seen_halted;
  logic       seen_decouple;
  logic       bad_unmasked;

  ti_stop_sequencer #(
    .NUM_PORTS(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .halt_req    (halt_req),
    .port_mask   (port_mask),
    .err_clr     (err_clr),
    .stop_req    (stop_req),
    .stop_ack    (stop_ack),
    .decouple    (decouple),
    .halted      (halted),
    .busy        (busy),
    .timeout_err (timeout_err),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  // wrapper model: updates on the falling edge, reset with the DUT
  always @(negedge clk) begin
    if (rst) begin
      h0       <= 8'h00;
      h1       <= 8'h00;
      h2       <= 8'h00;
      stop_ack <= 8'h00;
    end else begin
      h0       <= stop_req;
      h1       <= h0;
      h2       <= h1;
      stop_ack <= h2 & ack_en;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_watch(input logic [3:0] m);
    watch_mask    = m;
    seen_halted   = 1'b0;
    seen_decouple = 1'b0;
    bad_unmasked  = 1'b0;
  endtask

  // advance n cycles, sampling #1 after each rising edge
  task automatic step(input int n);
    logic [7:0] pairs;
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int p = 0; p < 4; p++) begin
        pairs[2*p]   = watch_mask[p];
        pairs[2*p+1] = watch_mask[p];
      end
      seen_halted   = seen_halted | halted;
      seen_decouple = seen_decouple | (|decouple);
      if (((stop_req & ~pairs) != 8'h00) || ((decouple & ~watch_mask) != 4'h0)) begin
        bad_unmasked = 1'b1;
      end
    end
  endtask

  // standard session: halt at cycle 0, acks after 3 cycles, release at cycle 6
  task automatic full_session(input string tag, input logic [3:0] m,
                              input logic [7:0] exp_req);
    clear_watch(m);
    port_mask = m;
    halt_req  = 1'b1;
    step(1);
    check({tag, "_c1_stop_req"}, 32'(stop_req), 32'(exp_req));
    check({tag, "_c1_busy"}, 32'(busy), 32'd1);
    check({tag, "_c1_pending"}, 32'(pending), 32'(m));
    step(3);
    check({tag, "_c4_decouple"}, 32'(decouple), 32'd0);
    step(1);
    check({tag, "_c5_decouple"}, 32'(decouple), 32'(m));
    check({tag, "_c5_halted"}, 32'(halted), 32'd0);
    step(1);
    check({tag, "_c6_halted"}, 32'(halted), 32'd1);
    check({tag, "_c6_busy"}, 32'(busy), 32'd0);
    halt_req = 1'b0;
    step(1);
    check({tag, "_c7_halted"}, 32'(halted), 32'd0);
    check({tag, "_c7_decouple"}, 32'(decouple), 32'd0);
    check({tag, "_c7_stop_req"}, 32'(stop_req), 32'(exp_req));
    step(1);
    check({tag, "_c8_stop_req"}, 32'(stop_req), 32'd0);
    step(3);
    check({tag, "_c11_busy"}, 32'(busy), 32'd1);
    step(1);
    check({tag, "_c12_busy"}, 32'(busy), 32'd0);
    check({tag, "_c12_outs"}, {stop_req, decouple, halted, pending, timeout_err}, 32'd0);
    check({tag, "_unmasked"}, 32'(bad_unmasked), 32'd0);
    step(2);
  endtask

  initial begin
    rst       = 1'b1;
    halt_req  = 1'b0;
    port_mask = 4'h0;
    err_clr   = 1'b0;
    ack_en    = 8'hFF;
    clear_watch(4'h0);
    step(2);
    check("rst_stop_req", 32'(stop_req), 32'd0);
    check("rst_decouple", 32'(decouple), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    rst = 1'b0;
    step(2);

    // all four ports
    full_session("all", 4'hF, 8'hFF);

    // ports 0 and 2 only
    full_session("m5", 4'h5, 8'h33);

    // timeout: port 2 never acks
    ack_en    = 8'hCF;
    clear_watch(4'hF);
    port_mask = 4'hF;
    halt_req  = 1'b1;
    step(1);
    check("to_c1_stop_req", 32'(stop_req), 32'hFF);
    step(15);
    check("to_c16_err", 32'(timeout_err), 32'd0);
    check("to_c16_pending", 32'(pending), 32'h4);
    check("to_c16_busy", 32'(busy), 32'd1);
    halt_req = 1'b0;
    step(1);
    check("to_c17_err", 32'(timeout_err), 32'd1);
    check("to_c17_stop_req", 32'(stop_req), 32'hFF);
    check("to_c17_pending", 32'(pending), 32'd0);
    check("to_c17_busy", 32'(busy), 32'd1);
    step(1);
    check("to_c18_stop_req", 32'(stop_req), 32'd0);
    step(3);
    check("to_c21_busy", 32'(busy), 32'd1);
    step(1);
    check("to_c22_busy", 32'(busy), 32'd0);
    check("to_c22_err_sticky", 32'(timeout_err), 32'd1);
    check("to_never_halted", 32'(seen_halted), 32'd0);
    check("to_never_decouple", 32'(seen_decouple), 32'd0);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("to_err_clr", 32'(timeout_err), 32'd0);
    step(2);

    // abort while STOPPING, only port 0 acks
    ack_en = 8'h03;
    clear_watch(4'hF);
    halt_req = 1'b1;
    step(6);
    check("ab_c6_pending", 32'(pending), 32'hE);
    check("ab_c6_busy", 32'(busy), 32'd1);
    halt_req = 1'b0;
    step(1);
    check("ab_c7_stop_req", 32'(stop_req), 32'hFF);
    step(1);
    check("ab_c8_stop_req", 32'(stop_req), 32'd0);
    step(3);
    check("ab_c11_busy", 32'(busy), 32'd1);
    step(1);
    check("ab_c12_busy", 32'(busy), 32'd0);
    check("ab_never_decouple", 32'(seen_decouple), 32'd0);
    check("ab_never_halted", 32'(seen_halted), 32'd0);
    check("ab_err", 32'(timeout_err), 32'd0);
    step(2);

    // partial ack: port 0 only acks its write side
    ack_en = 8'hFD;
    clear_watch(4'hF);
    halt_req = 1'b1;
    step(8);
    check("pa_c8_halted", 32'(halted), 32'd0);
    check("pa_c8_decouple", 32'(decouple), 32'd0);
    check("pa_c8_pending", 32'(pending), 32'h1);
    check("pa_c8_busy", 32'(busy), 32'd1);
    ack_en = 8'hFF;
    step(1);
    check("pa_c9_decouple", 32'(decouple), 32'hF);
    check("pa_c9_no_early_halt", 32'(seen_halted), 32'd0);
    step(1);
    check("pa_c10_halted", 32'(halted), 32'd1);

    // asynchronous reset while HALTED
    #2;
    rst = 1'b1;
    #1;
    check("ar_stop_req", 32'(stop_req), 32'd0);
    check("ar_decouple", 32'(decouple), 32'd0);
    check("ar_halted", 32'(halted), 32'd0);
    halt_req = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);
    full_session("post_rst", 4'hF, 8'hFF);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
